ex_counter_ctrl: RTL and testbench

Sequencing controller for the 16-bit `ex_counter` datapath. It drives the counter's clear and enable, and watches the count value it returns. Each run counts to a programmed terminal value, either once or periodically, with pause, resume and stop. On completion it emits a done pulse and a sticky interrupt flag. It sits beside `ex_counter` in the timer top level and owns every write to the counter.

---
 rtl/ex_counter_ctrl_pkg.sv | 20 ++
 rtl/ex_counter_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ex_counter_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ex_counter_ctrl_pkg
// Shared definitions for the ex_counter sequencing controller: FSM state
// encoding, run-mode constants and the default count width.
// -----------------------------------------------------------------------------
package ex_counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/ex_counter_ctrl.sv
// -----------------------------------------------------------------------------
// ex_counter_ctrl
// Sequencing controller for the ex_counter datapath. Runs the counter from 0
// up to a latched terminal value, once or periodically, with pause/resume and
// stop. Emits a one-cycle done per completed period and a sticky irq.
//
// Ports
//   clk      rising-edge clock shared with ex_counter
//   rst      asynchronous active-low reset
//   start    begin a run (only honoured in IDLE)
//   stop     abort the run, return to IDLE
//   pause    freeze counting (RUN -> PAUSE)
//   resume   continue counting (PAUSE -> RUN)
//   mode     0 one-shot, 1 periodic; latched on an accepted start
//   period   terminal count; latched on an accepted start
//   irq_clr  clear the sticky irq
//   cnt_in   count value returned by ex_counter
//   cnt_clr  counter synchronous clear (registered)
//   cnt_en   counter enable (combinational)
//   busy     high in CLEAR, RUN and PAUSE (registered)
//   done     one-cycle pulse per completed period (registered)
//   irq      sticky, set by every done (registered)
//   err      one-cycle pulse when a start with period 0 is rejected
// -----------------------------------------------------------------------------
module ex_counter_ctrl
    import ex_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             resume,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic             irq_clr,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic             err
);

    state_e           state_r;
    logic [WIDTH-1:0] period_r;
    logic             mode_r;
    logic             cnt_clr_r;
    logic             busy_r;
    logic             done_r;
    logic             irq_r;
    logic             err_r;

    logic             run_go_s;
    logic             terminal_s;
    logic             cnt_en_s;

    // RUN with neither stop nor pause pending; terminal when count meets period
    always_comb begin
        run_go_s   = 1'b0;
        terminal_s = 1'b0;
        cnt_en_s   = 1'b0;
        if (state_r == ST_RUN) begin
            run_go_s = !stop && !pause;
        end else begin
            run_go_s = 1'b0;
        end
        terminal_s = (cnt_in == period_r);
        // Enable is dropped on the terminal cycle so the counter never overshoots
        cnt_en_s   = run_go_s && !terminal_s;
    end

    // Controller FSM with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            period_r  <= {WIDTH{1'b0}};
            mode_r    <= MODE_ONESHOT;
            cnt_clr_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            irq_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;

            // A done in the same cycle as irq_clr keeps irq set
            if (run_go_s && terminal_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start && (period != {WIDTH{1'b0}})) begin
                        period_r  <= period;
                        mode_r    <= mode;
                        state_r   <= ST_CLEAR;
                        cnt_clr_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else if (start) begin
                        err_r     <= 1'b1;
                        cnt_clr_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else begin
                        cnt_clr_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    // The clear has already been presented this cycle, so a
                    // stop here still leaves the counter at zero
                    cnt_clr_r <= 1'b0;
                    if (stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        state_r   <= ST_IDLE;
                        cnt_clr_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else if (pause) begin
                        state_r   <= ST_PAUSE;
                        cnt_clr_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end else if (terminal_s) begin
                        done_r <= 1'b1;
                        if (mode_r == MODE_PERIODIC) begin
                            state_r   <= ST_CLEAR;
                            cnt_clr_r <= 1'b1;
                            busy_r    <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            cnt_clr_r <= 1'b0;
                            busy_r    <= 1'b0;
                        end
                    end else begin
                        cnt_clr_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end

                ST_PAUSE: begin
                    cnt_clr_r <= 1'b0;
                    if (stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (resume) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cnt_clr_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_clr = cnt_clr_r;
    assign cnt_en  = cnt_en_s;
    assign busy    = busy_r;
    assign done    = done_r;
    assign irq     = irq_r;
    assign err     = err_r;

endmodule

// File: tb/tb_ex_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ex_counter_ctrl
// Bench for ex_counter_ctrl. A behavioural counter stands in for ex_counter;
// a run-level reference model predicts every output each cycle. Directed
// scenarios pin the model with hand-computed latencies, then a random phase
// exercises all control inputs.
// -----------------------------------------------------------------------------
module tb_ex_counter_ctrl;

    localparam int W = 16;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         start   = 1'b0;
    logic         stop    = 1'b0;
    logic         pause   = 1'b0;
    logic         resume  = 1'b0;
    logic         mode    = 1'b0;
    logic         irq_clr = 1'b0;
    logic [W-1:0] period  = 16'd0;
    logic [W-1:0] cnt     = 16'd0;
    logic         cnt_clr, cnt_en, busy, done, irq, err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: run-level view of the controller plus expected count
    bit           m_busy  = 1'b0;
    bit           m_clear = 1'b0;
    bit           m_pause = 1'b0;
    bit           m_mode  = 1'b0;
    bit           m_done  = 1'b0;
    bit           m_irq   = 1'b0;
    bit           m_err   = 1'b0;
    logic [W-1:0] m_per   = 16'd0;
    logic [W-1:0] m_cnt   = 16'd0;

    ex_counter_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .resume  (resume),
        .mode    (mode),
        .period  (period),
        .irq_clr (irq_clr),
        .cnt_in  (cnt),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .busy    (busy),
        .done    (done),
        .irq     (irq),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Stand-in for ex_counter: clear dominates enable, no reset
    always @(posedge clk) begin
        if (cnt_clr) cnt <= 16'd0;
        else if (cnt_en) cnt <= cnt + 16'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_en();
        return m_busy && !m_clear && !m_pause && !stop && !pause && (m_cnt != m_per);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_clear = 1'b0; m_pause = 1'b0; m_mode = 1'b0;
        m_done = 1'b0; m_irq = 1'b0; m_err = 1'b0; m_per = 16'd0;
    endtask

    task automatic idle_in();
        start = 1'b0; stop = 1'b0; pause = 1'b0; resume = 1'b0; irq_clr = 1'b0;
    endtask

    // One clock: check comb enable, advance model, compare registered outputs
    task automatic tick();
        bit           en;
        logic [W-1:0] cur;
        #1;
        en  = model_en();
        cur = m_cnt;
        chk("cnt_en", cnt_en, en);
        if (m_clear) m_cnt = 16'd0;
        else if (en) m_cnt = m_cnt + 16'd1;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_busy) begin
            if (start && period != 16'd0) begin
                m_per = period; m_mode = mode; m_busy = 1'b1; m_clear = 1'b1;
            end else if (start) begin
                m_err = 1'b1;
            end
        end else if (m_clear) begin
            m_clear = 1'b0;
            if (stop) m_busy = 1'b0;
        end else if (m_pause) begin
            if (stop) begin m_pause = 1'b0; m_busy = 1'b0; end
            else if (resume) m_pause = 1'b0;
        end else begin
            if (stop) m_busy = 1'b0;
            else if (pause) m_pause = 1'b1;
            else if (cur == m_per) begin
                m_done = 1'b1;
                if (m_mode) m_clear = 1'b1;
                else m_busy = 1'b0;
            end
        end
        if (m_done) m_irq = 1'b1;
        else if (irq_clr) m_irq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("cnt_clr", cnt_clr, m_clear);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("irq", irq, m_irq);
        chk("err", err, m_err);
        chk("count", cnt, m_cnt);
    endtask

    int first_done;
    int n_done;
    logic irq_before;
    logic [W-1:0] held;

    initial begin
        // ---- Reset held with start asserted ----
        #2;
        rst = 1'b0;
        start = 1'b1; mode = 1'b0; period = 16'd5;
        repeat (3) begin
            @(negedge clk);
            chk("rst_cnt_clr", cnt_clr, 1'b0);
            chk("rst_cnt_en", cnt_en, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_irq", irq, 1'b0);
            chk("rst_err", err, 1'b0);
        end
        model_reset();
        rst = 1'b1;

        // ---- One-shot P=5 with an ignored mid-run start(period 9) ----
        start = 1'b1; mode = 1'b0; period = 16'd5;
        tick();
        chk("busy_after_start", busy, 1'b1);
        chk("clr_cycle0", cnt_clr, 1'b1);
        first_done = -1;
        for (int i = 1; i <= 9; i++) begin
            idle_in();
            if (i == 3) begin start = 1'b1; period = 16'd9; mode = 1'b1; end
            tick();
            if (done && first_done < 0) first_done = i;
        end
        chk("oneshot_latency", first_done, 7);
        chk("oneshot_hold", cnt, 16'd5);
        chk("oneshot_irq", irq, 1'b1);
        chk("oneshot_idle", busy, 1'b0);
        idle_in(); irq_clr = 1'b1; tick();
        chk("irq_cleared", irq, 1'b0);

        // ---- Periodic P=3, irq_clr colliding with done ----
        idle_in(); start = 1'b1; mode = 1'b1; period = 16'd3;
        tick();
        n_done = 0;
        for (int i = 1; i <= 11; i++) begin
            idle_in();
            if (i == 8 || i == 10) irq_clr = 1'b1;
            if (i == 11) stop = 1'b1;
            tick();
            if (done) begin
                n_done++;
                chk("periodic_spacing", i % 5, 0);
            end
            if (i == 4) chk("periodic_peak", cnt, 16'd3);
            if (i == 6) chk("periodic_wrap", cnt, 16'd0);
            if (i == 8) chk("periodic_irq_clr", irq, 1'b0);
            if (i == 10) chk("periodic_irq_wins", irq, 1'b1);
        end
        chk("periodic_count", n_done, 2);
        chk("periodic_stopped", busy, 1'b0);

        // ---- Pause P=10: 6 idle pause cycles plus entry/exit -> done at 20 ----
        idle_in(); start = 1'b1; mode = 1'b0; period = 16'd10;
        tick();
        first_done = -1;
        for (int i = 1; i <= 24; i++) begin
            idle_in();
            if (i == 6) begin chk("pause_at4", cnt, 16'd4); pause = 1'b1; end
            if (i == 13) resume = 1'b1;
            tick();
            if (i == 12) chk("pause_held", cnt, 16'd4);
            if (done && first_done < 0) first_done = i;
        end
        chk("pause_latency", first_done, 20);

        // ---- Stop on the terminal cycle ----
        idle_in(); irq_clr = 1'b1; tick();
        idle_in(); start = 1'b1; mode = 1'b0; period = 16'd4;
        tick();
        irq_before = irq;
        n_done = 0;
        for (int i = 1; i <= 9; i++) begin
            idle_in();
            if (i == 6) begin chk("stop_at_term", cnt, 16'd4); stop = 1'b1; end
            tick();
            if (done) n_done++;
        end
        chk("stop_no_done", n_done, 0);
        chk("stop_irq_kept", irq, 1'b0);
        chk("stop_irq_same", irq, irq_before);
        chk("stop_idle", busy, 1'b0);
        idle_in(); start = 1'b1; period = 16'd4; tick();
        idle_in(); tick();
        chk("restart_cleared", cnt, 16'd0);
        idle_in(); stop = 1'b1; tick();

        // ---- Rejected start ----
        idle_in(); start = 1'b1; period = 16'd0; tick();
        chk("reject_err", err, 1'b1);
        chk("reject_busy", busy, 1'b0);
        idle_in(); tick();
        chk("reject_err_pulse", err, 1'b0);

        // ---- Reset mid-run: outputs drop at once, count held ----
        idle_in(); start = 1'b1; mode = 1'b1; period = 16'd8; tick();
        idle_in(); repeat (4) tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_en", cnt_en, 1'b0);
        chk("midrst_clr", cnt_clr, 1'b0);
        held = cnt;
        @(negedge clk);
        chk("midrst_hold", cnt, held);
        chk("midrst_model_cnt", cnt, m_cnt);
        model_reset();
        rst = 1'b1;

        // ---- Random phase ----
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 99) < 20);
            stop    = ($urandom_range(0, 99) < 3);
            pause   = ($urandom_range(0, 99) < 5);
            resume  = ($urandom_range(0, 99) < 20);
            irq_clr = ($urandom_range(0, 99) < 5);
            mode    = 1'($urandom_range(0, 1));
            period  = 16'($urandom_range(0, 12));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
